result_collector: RTL

Result-side counterpart of the batch stimulus streamer. Samples the DUT's per-item result stream and accumulates NUM results into one packed batch register. It then presents that batch to the host-side consumer (the DPI receive path) with a valid/ready handshake. It sits between the DUT result port and the testbench export layer, and counts any results lost while a batch is awaiting pickup.

---
 rtl/result_collector_pkg.sv | 24 ++
 rtl/result_collector_timer.sv | 45 ++++
 rtl/result_collector.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/result_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector_pkg
//  Description : Shared types and constants for the result collector.
//                state_t  - collector FSM states (FILL, HOLD)
//                c_DROP_W - width of the saturating drop counter
//                calc_len_w() - width needed to hold a count of 0..num
//  Revision    : 1.0 - initial release
// ============================================================================
package result_collector_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int c_DROP_W = 16;

    function automatic int calc_len_w(input int num);
        return $clog2(num + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_collector_timer.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector_timer
//  Description : Idle counter for partial-batch flushing. Counts cycles with
//                no accept while run_i is high; expire_o flags the cycle that
//                is the TIMEOUT-th idle cycle in a row.
//  Ports       : clk_i     - clock
//                reset_i   - synchronous active-high reset
//                run_i     - collector is in FILL holding at least one item
//                accept_i  - an item is accepted this cycle
//                expire_o  - this cycle completes the idle window
//  Revision    : 1.0 - initial release
// ============================================================================
module result_collector_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic accept_i,
    output logic expire_o
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // r_cnt holds the number of idle cycles already completed; the cycle in
    // which it equals TIMEOUT-1 is the TIMEOUT-th idle cycle. Leaving run_i
    // (HOLD entry or empty buffer) clears it, so FILL re-entry starts fresh.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (!run_i || accept_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire_o = run_i && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector
//  Description : Collects NUM result items into one packed batch register and
//                hands the batch to a consumer with a valid/ready handshake.
//                Items presented while not ready are counted as drops.
//                Optional feature macro: RESULT_COLLECTOR_TIMEOUT_EN - flush a
//                partial batch after TIMEOUT idle cycles.
//  Ports       : clk_i         - clock
//                reset_i       - synchronous active-high reset
//                res_valid_i   - result item present
//                res_i         - result item
//                res_ready_o   - collector can accept an item (registered)
//                batch_o       - packed batch, item k at [k*ITEM_WIDTH +: ITEM_WIDTH]
//                batch_len_o   - number of valid items in batch_o
//                batch_valid_o - batch presented
//                batch_ready_i - consumer takes batch
//                drop_cnt_o    - saturating count of dropped items
//  Revision    : 1.0 - initial release
// ============================================================================
module result_collector
    import result_collector_pkg::*;
#(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         res_valid_i,
    input  logic [ITEM_WIDTH-1:0]        res_i,
    output logic                         res_ready_o,
    output logic [NUM*ITEM_WIDTH-1:0]    batch_o,
    output logic [$clog2(NUM+1)-1:0]     batch_len_o,
    output logic                         batch_valid_o,
    input  logic                         batch_ready_i,
    output logic [15:0]                  drop_cnt_o
);

    localparam int c_IDX_W = $clog2(NUM);
    localparam int c_LEN_W = calc_len_w(NUM);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM - 1);
    localparam logic [c_LEN_W-1:0] c_FULL_LEN = c_LEN_W'(NUM);

    if (NUM < 2) begin : g_chk_num
        $error("result_collector: NUM must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_chk_timeout
        $error("result_collector: TIMEOUT must be at least 2");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ready;
    logic [c_IDX_W-1:0]      r_wr_idx;
    logic [c_LEN_W-1:0]      r_len;
    logic [c_DROP_W-1:0]     r_drop;
    logic [ITEM_WIDTH-1:0]   r_slot [NUM];

    logic w_accept;
    logic w_drop;
    logic w_complete;
    logic w_expire;
    logic w_flush;

    assign w_accept   = res_valid_i && r_ready;
    assign w_drop     = res_valid_i && !r_ready;
    assign w_complete = w_accept && (r_wr_idx == c_LAST_IDX);
    // A same-cycle accept beats the idle expiry.
    assign w_flush    = w_expire && !w_accept;

`ifdef RESULT_COLLECTOR_TIMEOUT_EN
    logic w_run;
    assign w_run = (r_state == ST_FILL) && (r_wr_idx != '0);

    result_collector_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .run_i    (w_run),
        .accept_i (w_accept),
        .expire_o (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_complete || w_flush) w_state_nxt = ST_HOLD;
            ST_HOLD: if (batch_ready_i)         w_state_nxt = ST_FILL;
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Ready is registered from the next state, so it stays low for the first
    // cycle after reset and drops in the same edge that enters HOLD.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= ST_FILL;
            r_ready  <= 1'b0;
            r_wr_idx <= '0;
            r_len    <= '0;
            r_drop   <= '0;
            for (int k = 0; k < NUM; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_FILL);

            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end

            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        r_slot[r_wr_idx] <= res_i;
                        if (w_complete) begin
                            r_wr_idx <= '0;
                            r_len    <= c_FULL_LEN;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end else if (w_flush) begin
                        r_wr_idx <= '0;
                        r_len    <= c_LEN_W'(r_wr_idx);
                    end
                end
                ST_HOLD: begin
                    // Clearing on pickup keeps unused slots zero for the
                    // next (possibly partial) batch.
                    if (batch_ready_i) begin
                        r_len <= '0;
                        for (int k = 0; k < NUM; k++) begin
                            r_slot[k] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM; k++) begin : g_pack
        assign batch_o[k*ITEM_WIDTH +: ITEM_WIDTH] = r_slot[k];
    end

    assign res_ready_o   = r_ready;
    assign batch_valid_o = (r_state == ST_HOLD);
    assign batch_len_o   = r_len;
    assign drop_cnt_o    = r_drop;

endmodule
`default_nettype wire
